// File: rtl/key_debounce_pulse_pkg.sv
// Shared types and board timing defaults for the pushbutton front end.
package key_debounce_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PRESS_CHK = 2'b01,
        HELD      = 2'b10,
        REL_CHK   = 2'b11
    } state_t;

    // 50 MHz board clock
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5_000_000;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounced button: clean level plus press/release/auto-repeat pulses.
module key_debounce_pulse
    import key_debounce_pulse_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned MAXV =
        max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CW = $clog2(MAXV) + 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] REP_FIRST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] REP_NEXT  = CW'(REPEAT_PERIOD - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic          s_in;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] rcnt, rcnt_nxt;
    logic          first, first_nxt;
    logic          press_nxt, rel_nxt, rep_nxt, level_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (s_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rcnt        <= '0;
            first       <= 1'b1;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rcnt        <= rcnt_nxt;
            first       <= first_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= rel_nxt;
            btn_repeat  <= rep_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rcnt_nxt  = rcnt;
        first_nxt = first;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        rep_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (s_in) begin
                    state_nxt = PRESS_CHK;
                    cnt_nxt   = '0;
                end
            end
            PRESS_CHK: begin
                if (!s_in) begin
                    state_nxt = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    rcnt_nxt  = '0;
                    first_nxt = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            HELD: begin
                if (!s_in) begin
                    state_nxt = REL_CHK;
                    cnt_nxt   = '0;
                    rcnt_nxt  = sat_inc(rcnt);
                end else if (REPEAT_EN &&
                             rcnt >= (first ? REP_FIRST : REP_NEXT)) begin
                    rep_nxt   = 1'b1;
                    rcnt_nxt  = '0;
                    first_nxt = 1'b0;
                end else begin
                    rcnt_nxt = sat_inc(rcnt);
                end
            end
            REL_CHK: begin
                // repeat timer keeps running but cannot fire here
                rcnt_nxt = sat_inc(rcnt);
                if (s_in) begin
                    state_nxt = HELD;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                end
            end
            default: state_nxt = IDLE;
        endcase
        level_nxt = (state_nxt == HELD) || (state_nxt == REL_CHK);
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench: press, bounce, glitch, repeat, release, reset mid-hold.
module tb_key_debounce_pulse;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b0;

    logic lv, pr, rl, rp;
    logic lv_n, pr_n, rl_n, rp_n;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (lv),
        .btn_press   (pr),
        .btn_release (rl),
        .btn_repeat  (rp)
    );

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) u_dut_norep (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (lv_n),
        .btn_press   (pr_n),
        .btn_release (rl_n),
        .btn_repeat  (rp_n)
    );

    task automatic chk(input string tag, input int k,
                       input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%b expected=%b",
                   tag, k, obs, exp);
        end
    endtask

    task automatic now_chk(input string tag, input int k,
                           input logic e_lv, input logic e_pr,
                           input logic e_rl, input logic e_rp);
        chk({tag, ".level"}, k, lv, e_lv);
        chk({tag, ".press"}, k, pr, e_pr);
        chk({tag, ".release"}, k, rl, e_rl);
        chk({tag, ".repeat"}, k, rp, e_rp);
        chk({tag, ".norep.level"}, k, lv_n, e_lv);
        chk({tag, ".norep.press"}, k, pr_n, e_pr);
        chk({tag, ".norep.release"}, k, rl_n, e_rl);
        chk({tag, ".norep.repeat"}, k, rp_n, 1'b0);
    endtask

    task automatic cyc(input string tag, input int k,
                       input logic e_lv, input logic e_pr,
                       input logic e_rl, input logic e_rp);
        @(posedge clk);
        #1;
        now_chk(tag, k, e_lv, e_pr, e_rl, e_rp);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        now_chk("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc("idle", k, 1'b0, 1'b0, 1'b0, 1'b0);

        // clean press, hold with auto-repeat, then release
        btn_raw = 1'b1;
        for (int k = 0; k <= 28; k++)
            cyc("press_hold", k, k >= 6, k == 6, 1'b0,
                k >= 16 && (k - 16) % 3 == 0);
        btn_raw = 1'b0;
        for (int k = 29; k <= 38; k++)
            cyc("release", k, k < 35, 1'b0, k == 35, 1'b0);

        // bounce 1,0,1,0 every 2 cycles, then steady high
        for (int k = 0; k <= 16; k++) begin
            btn_raw = (k >= 8) ? 1'b1 : ((k % 4) < 2);
            cyc("bounce", k, k >= 14, k == 14, 1'b0, 1'b0);
        end
        btn_raw = 1'b0;
        for (int k = 17; k <= 25; k++)
            cyc("bounce_rel", k, k < 23, 1'b0, k == 23, 1'b0);

        // 3-cycle glitch must not be accepted
        for (int k = 0; k <= 9; k++) begin
            btn_raw = (k < 3);
            cyc("glitch", k, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // reset asserted while held
        btn_raw = 1'b1;
        for (int k = 0; k <= 8; k++)
            cyc("pre_rst", k, k >= 6, k == 6, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        now_chk("rst_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++)
            cyc("rst_hold", k, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k <= 8; k++)
            cyc("post_rst", k, k >= 6, k == 6, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_debounce_pulse.md
# key_debounce_pulse

Debounced pushbutton front end that turns a raw, bouncing board button into a clean level plus single-cycle press, release and auto-repeat pulses in the `clk` domain. It sits directly upstream of the BCD digit counter/display stages. Its `btn_press` output is meant to be used as a synchronous count enable, so downstream logic no longer clocks from a button-derived signal.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a level change (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_EN`, default 1: 1 enables the auto-repeat pulse generation.
- `REPEAT_DELAY`, default 25_000_000: cycles in HELD before the first `btn_repeat` (0.5 s).
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent `btn_repeat` pulses (0.1 s).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  1  raw button, asynchronous to `clk`, active-high, bouncing.
- `btn_level`  out  1  debounced level.
- `btn_press`  out  1  one-cycle pulse on each accepted 0→1.
- `btn_release`  out  1  one-cycle pulse on each accepted 1→0.
- `btn_repeat`  out  1  one-cycle pulse per auto-repeat tick while held.

## Operation
- `btn_raw` passes through a 2-FF synchronizer → `s_in`. Nothing else samples `btn_raw`.
- FSM states:
  - IDLE (level 0): `s_in`=1 → PRESS_CHK with stable counter cleared to 0.
  - PRESS_CHK (level 0): `s_in`=0 → IDLE. Otherwise the counter increments. When counter = `DEBOUNCE_CYCLES`-1 and `s_in`=1 → HELD, and `btn_press` is pulsed.
  - HELD (level 1): `s_in`=0 → REL_CHK with counter cleared.
  - REL_CHK (level 1): `s_in`=1 → HELD. Otherwise the counter increments. When counter = `DEBOUNCE_CYCLES`-1 and `s_in`=0 → IDLE, and `btn_release` is pulsed.
- Repeat counter:
  - Cleared on entry to HELD from PRESS_CHK.
  - Counts in HELD and REL_CHK; a bounce back into HELD does not reset it.
  - Fires `btn_repeat` at `REPEAT_DELAY` cycles, then every `REPEAT_PERIOD` cycles.
  - Gated off when `REPEAT_EN`=0.
  - Frozen (no pulses) while in REL_CHK.
- Counter width: `$clog2` of the largest parameter plus 1. Counters saturate and never wrap.
- `btn_press`, `btn_release` and `btn_repeat` are mutually exclusive in any cycle. `btn_repeat` never coincides with `btn_press`.

## Timing
- All outputs are registered.
- Reset values: `btn_level`=0, all pulses 0, state IDLE, all counters 0, synchronizer flops 0.
- Press latency: `btn_raw` held high from clock edge 0 → `btn_press` high in the cycle following edge `DEBOUNCE_CYCLES`+2. `btn_level` rises in the same cycle.
- Release latency is symmetric: `btn_release` and the `btn_level` fall appear `DEBOUNCE_CYCLES`+2 edges after `btn_raw` falls.
- Any glitch shorter than `DEBOUNCE_CYCLES` samples produces no output change.
- Reset asserted mid-press: all outputs go to 0 immediately (asynchronous). After deassertion with the button still held, a fresh full debounce period is required, then `btn_press` fires.
- Button held at power-up is treated the same way: one `btn_press` after debounce.

## Structure
- Shared package/include file holds:
  - FSM state encodings (IDLE, PRESS_CHK, HELD, REL_CHK; 2-bit).
  - Default timing constants for the 50 MHz board clock.
- Sub-module `sync_2ff` (1-bit, async active-low reset to 0) is reused for switch inputs elsewhere.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press: `btn_raw` 0→1 at edge 0, held → `btn_press` high for exactly 1 cycle after edge 6; `btn_level`=1 from then.
- Bounce: `btn_raw` toggles 1,0,1,0 every 2 cycles, then stays 1 → exactly one `btn_press`, 4+2 edges after the final rise; no `btn_release`.
- Short glitch: 3-cycle high pulse on `btn_raw` → all outputs stay 0.
- Auto-repeat: hold for 25 cycles after `btn_press` → `btn_repeat` at +10, +13, +16, +19, +22; `REPEAT_EN`=0 → none.
- Release: drop `btn_raw` after hold → one `btn_release` 6 edges later; `btn_level`=0; no further repeats.
- Reset mid-hold: `rst_n`=0 for 2 cycles while held → outputs 0 asynchronously; after release of reset, one new `btn_press` 6 edges later.
